// File: rtl/ines_prg_loader_pkg.sv
// ines_pkg: shared types and constants for the iNES PRG loader.
//   - ines_state_e : loader FSM states (ST_MIRROR only when PRG_MIRROR_16K_EN
//                    is defined)
//   - ines_err_e   : err_code values reported on an aborted load
//   - INES_MAGIC, HEADER_BYTES, TRAINER_BYTES, PRG_BANK_BYTES : format constants
//   - magic_byte() : returns byte 0..3 of the "NES\x1A" signature
package ines_pkg;

  localparam logic [31:0] INES_MAGIC     = 32'h4E45531A;
  localparam int          HEADER_BYTES   = 16;
  localparam int          TRAINER_BYTES  = 512;
  localparam int          PRG_BANK_BYTES = 16384;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_TRAINER = 3'd2,
    ST_PRG     = 3'd3,
    ST_DONE    = 3'd4,
`ifdef PRG_MIRROR_16K_EN
    ST_MIRROR  = 3'd6,
`endif
    ST_ERROR   = 3'd5
  } ines_state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_BAD_MAGIC  = 2'd1,
    ERR_ZERO_BANKS = 2'd2,
    ERR_TOO_MANY   = 2'd3
  } ines_err_e;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = INES_MAGIC[31:24];
      2'd1:    b = INES_MAGIC[23:16];
      2'd2:    b = INES_MAGIC[15:8];
      default: b = INES_MAGIC[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ines_prg_loader_if.sv
// ines_prg_loader_if: byte stream in and ROM write port out of the loader.
//   rx_data/rx_valid/rx_ready : upstream byte stream. A byte transfers on a
//       posedge where rx_valid && rx_ready; rx_valid/rx_data are driven by the
//       source and must hold until that edge, rx_ready may drop at any edge
//       and never depends on rx_valid.
//   prg_addr/prg_we/prg_wdata : ROM write port, one write per prg_we cycle.
//   modport master : host/ROM side (drives the stream, observes writes)
//   modport slave  : loader side
interface ines_prg_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] prg_addr;
  logic        prg_we;
  logic [7:0]  prg_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, prg_addr, prg_we, prg_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, prg_addr, prg_we, prg_wdata
  );
endinterface

// File: rtl/ines_prg_loader_header_check.sv
// ines_header_check: validates the 16-byte iNES header as it streams past.
//   Clk, Reset    : clock, synchronous active-low reset
//   accept        : a header byte transfers this cycle
//   idx, data     : header byte index (0..15) and value
//   prg_banks     : header byte 4, latched
//   trainer       : header byte 6 bit 2, latched
//   err           : verdict for the current byte (combinational); magic
//                   errors on bytes 0..3, bank-count errors on byte 15
module ines_header_check
  import ines_pkg::*;
#(
  parameter int MAX_PRG_BANKS = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       accept,
  input  logic [3:0] idx,
  input  logic [7:0] data,
  output logic [7:0] prg_banks,
  output logic       trainer,
  output ines_err_e  err
);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      prg_banks <= 8'd0;
      trainer   <= 1'b0;
    end else if (accept) begin
      if (idx == 4'd4) prg_banks <= data;
      if (idx == 4'd6) trainer   <= data[2];
    end
  end

  // Byte 4 has been latched long before byte 15 arrives, so the bank-count
  // verdict can use the registered value.
  always_comb begin
    err = ERR_NONE;
    if (idx < 4'd4) begin
      if (data != magic_byte(idx[1:0])) err = ERR_BAD_MAGIC;
    end else if (idx == 4'(HEADER_BYTES - 1)) begin
      if (prg_banks == 8'd0)                       err = ERR_ZERO_BANKS;
      else if (prg_banks > 8'(MAX_PRG_BANKS))      err = ERR_TOO_MANY;
    end
  end

endmodule

// File: rtl/ines_prg_loader.sv
// ines_prg_loader: loads the PRG section of an iNES image, received as a byte
// stream, into the PRG ROM write port and holds the CPU in reset meanwhile.
// Optional macro PRG_MIRROR_16K_EN: for 1-bank images every byte is also
// written to addr|0x4000 (extra MIRROR cycle) so the full 32 KB is populated.
//   Clk, Reset : clock, synchronous active-low reset
//   start      : one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   bus        : stream in + ROM write port (slave modport)
//   prg_banks  : header byte 4
//   busy, cpu_hold : load in progress (identical)
//   done, error    : sticky until the next start/reset
//   err_code   : 1 bad magic, 2 zero banks, 3 too many banks
//   dbg_state  : FSM state for observation
module ines_prg_loader
  import ines_pkg::*;
#(
  parameter int MAX_PRG_BANKS = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  ines_prg_loader_if.slave    bus,
  output logic [7:0]          prg_banks,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic                cpu_hold,
  output ines_state_e         dbg_state
);

  ines_state_e state;
  ines_err_e   err_q;
  ines_err_e   hdr_err;
  logic        hdr_trainer;
  logic [16:0] cnt;
  logic [16:0] cnt_inc;
  logic [16:0] prg_total;
  logic        rx_ready;
  logic        take;
  logic        prg_we_q;
  logic [15:0] prg_addr_q;
  logic [7:0]  prg_wdata_q;

  assign take      = bus.rx_valid && rx_ready;
  assign cnt_inc   = cnt + 17'd1;
  // Only banks 1..MAX_PRG_BANKS ever reach PRG, so three bits are enough.
  assign prg_total = 17'(prg_banks[2:0]) * 17'(PRG_BANK_BYTES);

  ines_header_check #(.MAX_PRG_BANKS(MAX_PRG_BANKS)) u_hdr (
    .Clk       (Clk),
    .Reset     (Reset),
    .accept    (take && (state == ST_HEADER)),
    .idx       (cnt[3:0]),
    .data      (bus.rx_data),
    .prg_banks (prg_banks),
    .trainer   (hdr_trainer),
    .err       (hdr_err)
  );

  // DONE keeps accepting so trailing CHR data drains without stalling the host.
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      ST_HEADER, ST_TRAINER, ST_PRG, ST_DONE: rx_ready = 1'b1;
      default:                                rx_ready = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_q       <= ERR_NONE;
      cnt         <= 17'd0;
      prg_we_q    <= 1'b0;
      prg_addr_q  <= 16'd0;
      prg_wdata_q <= 8'd0;
    end else begin
      prg_we_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state <= ST_HEADER;
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
            err_q <= ERR_NONE;
            cnt   <= 17'd0;
          end
        end
        ST_HEADER: begin
          if (take) begin
            if (hdr_err != ERR_NONE) begin
              state <= ST_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
              err_q <= hdr_err;
            end else if (cnt == 17'(HEADER_BYTES - 1)) begin
              cnt   <= 17'd0;
              state <= hdr_trainer ? ST_TRAINER : ST_PRG;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        ST_TRAINER: begin
          if (take) begin
            if (cnt == 17'(TRAINER_BYTES - 1)) begin
              cnt   <= 17'd0;
              state <= ST_PRG;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        ST_PRG: begin
          if (take) begin
            prg_we_q    <= 1'b1;
            prg_addr_q  <= cnt[15:0];
            prg_wdata_q <= bus.rx_data;
            cnt         <= cnt_inc;
`ifdef PRG_MIRROR_16K_EN
            if (prg_banks == 8'd1) begin
              state <= ST_MIRROR;
            end else
`endif
            if (cnt_inc == prg_total) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
`ifdef PRG_MIRROR_16K_EN
        // Second copy of the byte just written; wdata is still held.
        ST_MIRROR: begin
          prg_we_q   <= 1'b1;
          prg_addr_q <= prg_addr_q | 16'h4000;
          if (cnt == prg_total) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ST_PRG;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.prg_we    = prg_we_q;
  assign bus.prg_addr  = prg_addr_q;
  assign bus.prg_wdata = prg_wdata_q;
  assign err_code      = err_q;
  assign cpu_hold      = busy;
  assign dbg_state     = state;

endmodule

// File: doc/ines_prg_loader.md
Name: ines_prg_loader

Overview:
- Upstream feeder for the PRG ROM memory: accepts an iNES image as a byte stream (UART/host side).
- Validates the 16-byte header and skips the optional trainer.
- Writes PRG bytes into the ROM through its address/WE/data write port, then reports done.
- Holds the CPU in reset while a load is in progress.

Parameters:
- MAX_PRG_BANKS, 2, maximum accepted 16 KB PRG banks (32 KB ROM).
- HEADER_BYTES, 16, iNES header length.
- TRAINER_BYTES, 512, trainer length skipped when header byte 6 bit 2 is set.

Ports:
- Clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept; a byte transfers when rx_valid && rx_ready at posedge.
- prg_addr  out  16  ROM write address.
- prg_we  out  1  ROM write enable, one-cycle pulse per write.
- prg_wdata  out  8  ROM write data.
- prg_banks  out  8  header byte 4, latched.
- busy  out  1  load in progress.
- done  out  1  level; set on successful completion.
- error  out  1  level; load aborted.
- err_code  out  2  1=bad magic, 2=zero banks, 3=too many banks.
- cpu_hold  out  1  CPU reset request; equals busy.

Behaviour:
- Reset (Reset=0 at posedge):
  - state=IDLE; all outputs and counters 0.
  - Reset mid-load aborts immediately; partially written ROM contents are left as-is.
- States: IDLE, HEADER, TRAINER, PRG, MIRROR (only with the macro), DONE, ERROR.
- IDLE / DONE / ERROR + start:
  - go to HEADER; clear done, error, err_code and the byte counter; set busy.
  - start is ignored in all other states.
- rx_ready:
  - 1 in HEADER, TRAINER, PRG and DONE.
  - 0 in IDLE, ERROR and MIRROR.
  - In DONE, accepted bytes (CHR data, trailing bytes) are discarded, so upstream never stalls.
- HEADER (counts 16 accepted bytes, 0..15):
  - Bytes 0..3 must be 0x4E 0x45 0x53 0x1A. On the first mismatch, go to ERROR with err_code=1 on the cycle after that byte is accepted; remaining header bytes are not consumed.
  - Byte 4 latched to prg_banks.
  - Byte 6 bit 2 latched as the trainer flag.
  - After byte 15:
    - prg_banks==0 → ERROR, code 2.
    - prg_banks>MAX_PRG_BANKS → ERROR, code 3.
    - otherwise → TRAINER if the flag is set, else PRG.
- TRAINER: accept and discard 512 bytes, then go to PRG.
- PRG:
  - The byte count target is prg_banks*16384 (17-bit counter).
  - An accepted byte produces a write one cycle later: prg_we=1, prg_addr=count[15:0], prg_wdata=byte (registered).
  - prg_addr/prg_wdata stay stable for the whole cycle, so the ROM's negedge write captures them.
  - When the last byte is accepted → DONE: busy=0, done=1, cpu_hold=0 from the next cycle. The final write pulse is issued in that same next cycle.
- rx_valid low stalls without writing; the counter holds.
- error/done remain set until the next start or reset.

Optional Feature:
- Macro: PRG_MIRROR_16K_EN.
- Defined:
  - When prg_banks==1, each PRG byte is written twice: at count, then at count|0x4000 on the following cycle via the MIRROR state.
  - rx_ready=0 during MIRROR, so throughput is at most one byte per 2 cycles.
  - The ROM's 32 KB image is then fully populated.
- Not defined:
  - Only 0x0000-0x3FFF is written for 16 KB images; the downstream address decode handles mirroring.
  - No MIRROR state exists.

Decomposition:
- Package ines_pkg holds:
  - the state enum;
  - the INES_MAGIC constant (0x4E45531A);
  - the PRG_BANK_BYTES=16384 and TRAINER_BYTES=512 constants;
  - the err_code enum.
- One natural sub-module, ines_header_check: byte index + byte in; latched bank count, trainer flag and error code out.

Test Plan:
- Valid 1-bank image, no trainer, bytes k&0xFF streamed back-to-back → 16384 prg_we pulses, addresses 0x0000..0x3FFF in order; done=1 one cycle after the last accept; cpu_hold low after that.
- Byte 2 = 0x54 ("NET") → error=1, err_code=1 the cycle after byte 2; rx_ready=0; zero prg_we pulses.
- Header byte 4 = 3 → error with err_code=3 after byte 15; prg_banks=3 latched; no writes.
- Trainer flag set, 2 banks, random rx_valid gaps → first write occurs only after 16+512 accepts; 32768 writes with contiguous addresses; no write while rx_valid=0.
- Reset=0 asserted at PRG byte 1000 → all outputs 0 next cycle; a subsequent start performs a clean load from byte 0.
- With PRG_MIRROR_16K_EN, 1 bank → byte 0x5A at count 5 is written to 0x0005 then 0x4005 on consecutive cycles; 32768 pulses total; rx_ready toggles 1/0.
